cpu_core_p: RTL

Parametrised multi-cycle accumulator-style CPU core, the next-generation replacement for the fixed 2-bit trainer CPU. It has a configurable datapath width and configurable instruction/data memory depths, and adds a zero flag, branches, an explicit output instruction, halt, and a run/stall control. It sits at the top of the trainer design: a host loads program words through the instruction-write port, then raises `run`, and observes results on `cpu_out`.

---
 rtl/cpu_core_p.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle accumulator-style CPU core.
//
// A host loads 16-bit program words through the instruction-write port,
// raises run, and watches results on cpu_out. Every instruction walks
// FETCH -> DECODE -> EXEC -> WB (four cycles). HALT parks the core in
// HALTED until reset.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   run         allows a new instruction to start (sampled in FETCH only)
//   instr_we    instruction-memory write enable
//   instr_addr  instruction-memory write address
//   instr_data  instruction-memory write data
//   cpu_out     last value emitted by OUT
//   out_valid   one-cycle pulse when cpu_out updates
//   halted      high once HALT has executed
//   pc_out      current program counter
//
// Instruction word: [15:13] opcode, [12:11] rd, [10:9] rs, [8] unused,
// [7:0] imm.
module cpu_core_p #(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               instr_we,
  input  logic [IMEM_AW-1:0] instr_addr,
  input  logic [15:0]        instr_data,
  output logic [DATA_W-1:0]  cpu_out,
  output logic               out_valid,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc_out
);

  localparam int IMEM_D = 1 << IMEM_AW;
  localparam int DMEM_D = 1 << DMEM_AW;

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ST   = 3'd2;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  state_t state, state_nxt;

  logic [15:0]        imem [IMEM_D];
  logic [DATA_W-1:0]  dmem [DMEM_D];
  logic [DATA_W-1:0]  regs [4];
  logic [IMEM_AW-1:0] pc;
  logic               z;
  logic [15:0]        ir;

  logic [DATA_W-1:0]  opa_p0, opb_p0;
  logic [DMEM_AW-1:0] daddr_p0;
  logic [DATA_W-1:0]  res_p1, ld_p1;

  logic [2:0]         op;
  logic [1:0]         rd, rs;
  logic [15:0]        imm_ext;
  logic [DATA_W-1:0]  imm_d;
  logic [IMEM_AW-1:0] imm_pc;
  logic               unused_bits;

  assign op      = ir[15:13];
  assign rd      = ir[12:11];
  assign rs      = ir[10:9];
  // imm widened to 16 bits first so that both zero-extension (DATA_W > 8)
  // and truncation (DATA_W < 8) fall out of one slice.
  assign imm_ext = {8'h00, ir[7:0]};
  assign imm_d   = imm_ext[DATA_W-1:0];
  assign imm_pc  = ir[IMEM_AW-1:0];
  assign unused_bits = ^{ir[8], imm_ext};

  assign pc_out = pc;

  function automatic logic [DATA_W-1:0] alu_op(input logic [1:0]        f,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (f)
      2'd0:    alu_op = a + b;
      2'd1:    alu_op = a - b;
      2'd2:    alu_op = a & b;
      default: alu_op = a ^ b;
    endcase
  endfunction

  // Instruction memory: writable at any time, never reset. A write to the
  // word being fetched on the same edge leaves the fetch with the old word.
  always_ff @(posedge clk) begin
    if (instr_we) imem[instr_addr] <= instr_data;
  end

  // Data memory store happens only on the EXEC edge; an async reset forces
  // the state away from EXEC, which cancels a pending store.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && op == OP_ST) dmem[daddr_p0] <= opa_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (run) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = (op == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // FETCH -> DECODE: instruction register
    if (state == S_FETCH && run) ir <= imem[pc];
    // DECODE -> EXEC: operands and data-memory address
    if (state == S_DECODE) begin
      opa_p0   <= regs[rd];
      opb_p0   <= regs[rs];
      daddr_p0 <= ir[DMEM_AW-1:0];
    end
    // EXEC -> WB: ALU result and load data
    if (state == S_EXEC) begin
      res_p1 <= alu_op(ir[1:0], opa_p0, opb_p0);
      ld_p1  <= dmem[daddr_p0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      z         <= 1'b0;
      cpu_out   <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_EXEC && op == OP_OUT) begin
        cpu_out   <= opa_p0;
        out_valid <= 1'b1;
      end
      // WB: register file, zero flag, program counter
      if (state == S_WB) begin
        case (op)
          OP_ALU: begin
            regs[rd] <= res_p1;
            z        <= (res_p1 == '0);
          end
          OP_LDI: regs[rd] <= imm_d;
          OP_LD: begin
            regs[rd] <= ld_p1;
            z        <= (ld_p1 == '0);
          end
          default: ;
        endcase
        case (op)
          OP_BZ:   pc <= z ? imm_pc : pc + IMEM_AW'(1);
          OP_JMP:  pc <= imm_pc;
          OP_HALT: halted <= 1'b1;
          default: pc <= pc + IMEM_AW'(1);
        endcase
      end
    end
  end

endmodule
